// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: register-file
// address width and the memory-wait FSM state encoding.
package pipeline_stall_ctrl_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } stall_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle of hazard inputs, memory handshake and pipeline-register controls
// exchanged between the stall sequencer (master) and the datapath (slave).
interface pipeline_stall_ctrl_if
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
    parameter int CNT_W      = 16
);

    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_mem_r_en;
    logic                  br_taken;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  mem_ready;

    logic                  pc_freeze;
    logic                  if2id_freeze;
    logic                  if2id_flush;
    logic                  id2exe_freeze;
    logic                  id2exe_bubble;
    logic                  exe2mem_freeze;
    logic                  mem2wb_bubble;
    logic                  mem_req;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_count;

    // Stall sequencer side: observes hazards, drives pipeline controls.
    modport master (
        input  id_src1, id_src2, id_two_src, exe_dest, exe_mem_r_en,
        input  br_taken, mem_r_en, mem_w_en, mem_ready,
        output pc_freeze, if2id_freeze, if2id_flush, id2exe_freeze,
        output id2exe_bubble, exe2mem_freeze, mem2wb_bubble,
        output mem_req, mem_timeout, stall_count
    );

    // Datapath side: reports hazards, obeys pipeline controls.
    modport slave (
        output id_src1, id_src2, id_two_src, exe_dest, exe_mem_r_en,
        output br_taken, mem_r_en, mem_w_en, mem_ready,
        input  pc_freeze, if2id_freeze, if2id_flush, id2exe_freeze,
        input  id2exe_bubble, exe2mem_freeze, mem2wb_bubble,
        input  mem_req, mem_timeout, stall_count
    );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in EXE whose destination feeds an
// operand of the instruction in ID. Register 0 is hard-wired, never a hazard.
module hazard_detect
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN
) (
    input  logic [REG_ADDR_W-1:0] id_src1_i,
    input  logic [REG_ADDR_W-1:0] id_src2_i,
    input  logic                  id_two_src_i,
    input  logic [REG_ADDR_W-1:0] exe_dest_i,
    input  logic                  exe_mem_r_en_i,
    output logic                  load_use_o
);

    logic src1Match;
    logic src2Match;

    // Compare the pending load destination against the operands actually read.
    always_comb begin
        src1Match  = (exe_dest_i == id_src1_i);
        src2Match  = id_two_src_i && (exe_dest_i == id_src2_i);
        load_use_o = exe_mem_r_en_i && (exe_dest_i != '0) && (src1Match || src2Match);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Memory stalls
// freeze everything and bubble MEM2WB; load-use stalls freeze the front and
// bubble ID2EXE once; taken branches flush IF2ID. A wait FSM bounds how long
// the data memory may hold off before latching a sticky timeout error.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.master bus
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    stall_state_e      stateQ, stateD;
    logic [WAIT_W-1:0] waitCntQ, waitCntD;
    logic              timeoutQ, timeoutD;
    logic [CNT_W-1:0]  stallCountQ;

    logic loadUse;
    logic memAcc;
    logic frontEval;
    logic pcFreeze;
    logic if2idFreeze;
    logic if2idFlush;
    logic id2exeFreeze;
    logic id2exeBubble;
    logic exe2memFreeze;
    logic mem2wbBubble;
    logic memReq;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) uHazard (
        .id_src1_i     (bus.id_src1),
        .id_src2_i     (bus.id_src2),
        .id_two_src_i  (bus.id_two_src),
        .exe_dest_i    (bus.exe_dest),
        .exe_mem_r_en_i(bus.exe_mem_r_en),
        .load_use_o    (loadUse)
    );

    // Next-state and control decode; the memory stall outranks the front-end
    // hazards, which are only looked at when the back of the pipe can move.
    always_comb begin
        stateD        = stateQ;
        waitCntD      = waitCntQ;
        timeoutD      = timeoutQ;
        frontEval     = 1'b0;
        pcFreeze      = 1'b0;
        if2idFreeze   = 1'b0;
        if2idFlush    = 1'b0;
        id2exeFreeze  = 1'b0;
        id2exeBubble  = 1'b0;
        exe2memFreeze = 1'b0;
        mem2wbBubble  = 1'b0;
        memAcc        = bus.mem_r_en || bus.mem_w_en;
        memReq        = memAcc && (stateQ != ERR);

        case (stateQ)
            RUN: begin
                if (memAcc && !bus.mem_ready) begin
                    pcFreeze      = 1'b1;
                    if2idFreeze   = 1'b1;
                    id2exeFreeze  = 1'b1;
                    exe2memFreeze = 1'b1;
                    mem2wbBubble  = 1'b1;
                    stateD        = MEM_WAIT;
                    waitCntD      = WAIT_W'(1);
                end else begin
                    frontEval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    stateD    = RUN;
                    waitCntD  = '0;
                    frontEval = 1'b1;
                end else begin
                    pcFreeze      = 1'b1;
                    if2idFreeze   = 1'b1;
                    id2exeFreeze  = 1'b1;
                    exe2memFreeze = 1'b1;
                    mem2wbBubble  = 1'b1;
                    if (waitCntQ == WAIT_LAST) begin
                        stateD   = ERR;
                        timeoutD = 1'b1;
                    end else begin
                        waitCntD = waitCntQ + WAIT_W'(1);
                    end
                end
            end
            ERR: begin
                pcFreeze      = 1'b1;
                if2idFreeze   = 1'b1;
                id2exeFreeze  = 1'b1;
                exe2memFreeze = 1'b1;
                mem2wbBubble  = 1'b1;
            end
            default: begin
                stateD = RUN;
            end
        endcase

        if (frontEval) begin
            if (loadUse) begin
                pcFreeze     = 1'b1;
                if2idFreeze  = 1'b1;
                id2exeBubble = 1'b1;
            end else if (bus.br_taken) begin
                if2idFlush = 1'b1;
            end
        end
    end

    // Reset gates every control so a pipeline held in reset sees a clean NOP stream.
    always_comb begin
        bus.pc_freeze      = !rst && pcFreeze;
        bus.if2id_freeze   = !rst && if2idFreeze;
        bus.if2id_flush    = !rst && if2idFlush;
        bus.id2exe_freeze  = !rst && id2exeFreeze;
        bus.id2exe_bubble  = !rst && id2exeBubble;
        bus.exe2mem_freeze = !rst && exe2memFreeze;
        bus.mem2wb_bubble  = !rst && mem2wbBubble;
        bus.mem_req        = !rst && memReq;
        bus.mem_timeout    = !rst && timeoutQ;
        bus.stall_count    = stallCountQ;
    end

    // FSM state, wait counter, sticky timeout and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= RUN;
            waitCntQ    <= '0;
            timeoutQ    <= 1'b0;
            stallCountQ <= '0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
            timeoutQ <= timeoutD;
            if (pcFreeze && (stallCountQ != '1)) begin
                stallCountQ <= stallCountQ + CNT_W'(1);
            end
        end
    end

endmodule
